// File: rtl/pulse_seq_pkg.sv
// Shared state encoding and default geometry for the pulse init sequencer.
// Optional late-command dropping in the top is enabled by PULSE_SEQ_LATE_CHECK_EN.
package pulse_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD_DEF = 2'd1,
    ST_LOAD_AMP = 2'd2,
    ST_RUN      = 2'd3
  } seq_state_e;

  localparam int DEF_NUM_QUBIT             = 8;
  localparam int DEF_QUBIT_ADDR_WIDTH      = 3;
  localparam int DEF_AMP_MEMORY_NUM_ENTRY  = 64;
  localparam int DEF_AMP_MEMORY_ADDR_WIDTH = 6;
  localparam int DEF_AMP_MEMORY_DATA_WIDTH = 32;
  localparam int DEF_AMP_WIDTH             = 16;
  localparam int DEF_MASK_WIDTH            = 2;
  localparam int DEF_GLB_COUNTER_WIDTH     = 24;
  localparam int DEF_CMD_FIFO_DEPTH        = 4;

  function automatic logic is_loading(input seq_state_e s);
    return (s == ST_LOAD_DEF) || (s == ST_LOAD_AMP);
  endfunction

endpackage

// File: rtl/pulse_seq_cmd_fifo.sv
// Synchronous command FIFO, head visible combinationally, registered occupancy count.
// Push is ignored when full and pop when empty; flush empties it in one cycle.
module pulse_seq_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & ~empty_o;
  assign head_dat_o = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/pulse_init_sequencer.sv
// Loads per-qubit default amp + amp memory from a cfg stream, then issues buffered commands 1/cycle (1-cycle registered).
// cfg_ready only while loading; cmd_ready = !fifo_full. Define PULSE_SEQ_LATE_CHECK_EN to drop late commands.
module pulse_init_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int NUM_QUBIT             = DEF_NUM_QUBIT,
  parameter int QUBIT_ADDR_WIDTH      = DEF_QUBIT_ADDR_WIDTH,
  parameter int AMP_MEMORY_NUM_ENTRY  = DEF_AMP_MEMORY_NUM_ENTRY,
  parameter int AMP_MEMORY_ADDR_WIDTH = DEF_AMP_MEMORY_ADDR_WIDTH,
  parameter int AMP_MEMORY_DATA_WIDTH = DEF_AMP_MEMORY_DATA_WIDTH,
  parameter int AMP_WIDTH             = DEF_AMP_WIDTH,
  parameter int MASK_WIDTH            = DEF_MASK_WIDTH,
  parameter int GLB_COUNTER_WIDTH     = DEF_GLB_COUNTER_WIDTH,
  parameter int CMD_FIFO_DEPTH        = DEF_CMD_FIFO_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [GLB_COUNTER_WIDTH-1:0]     glb_counter,
  input  logic                             start,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [AMP_MEMORY_DATA_WIDTH-1:0] cfg_data,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [NUM_QUBIT*MASK_WIDTH-1:0]  cmd_mask,
  input  logic [GLB_COUNTER_WIDTH-1:0]     cmd_start_time,
  output logic                             valid_out,
  output logic [NUM_QUBIT*MASK_WIDTH-1:0]  mask_out,
  output logic [GLB_COUNTER_WIDTH-1:0]     start_time_out,
  output logic [QUBIT_ADDR_WIDTH-1:0]      amp_memory_wr_sel,
  output logic                             amp_memory_wr_en,
  output logic [AMP_MEMORY_ADDR_WIDTH-1:0] amp_memory_wr_addr,
  output logic [AMP_MEMORY_DATA_WIDTH-1:0] amp_memory_wr_data,
  output logic [QUBIT_ADDR_WIDTH-1:0]      default_amp_wr_sel,
  output logic                             default_amp_wr_en,
  output logic [AMP_WIDTH-1:0]             default_amp_wr_data,
  output logic                             busy,
  output logic                             ready_run,
  output logic                             late_err
);

  localparam int MASK_BITS = NUM_QUBIT * MASK_WIDTH;
  localparam int CMD_W     = MASK_BITS + GLB_COUNTER_WIDTH;
  localparam logic [QUBIT_ADDR_WIDTH-1:0]      LAST_Q = QUBIT_ADDR_WIDTH'(NUM_QUBIT - 1);
  localparam logic [AMP_MEMORY_ADDR_WIDTH-1:0] LAST_E = AMP_MEMORY_ADDR_WIDTH'(AMP_MEMORY_NUM_ENTRY - 1);

  seq_state_e                       state_q;
  logic [QUBIT_ADDR_WIDTH-1:0]      q_q;
  logic [AMP_MEMORY_ADDR_WIDTH-1:0] e_q;
  logic                             def_wr_en_q;
  logic [QUBIT_ADDR_WIDTH-1:0]      def_wr_sel_q;
  logic [AMP_WIDTH-1:0]             def_wr_dat_q;
  logic                             amp_wr_en_q;
  logic [QUBIT_ADDR_WIDTH-1:0]      amp_wr_sel_q;
  logic [AMP_MEMORY_ADDR_WIDTH-1:0] amp_wr_addr_q;
  logic [AMP_MEMORY_DATA_WIDTH-1:0] amp_wr_dat_q;
  logic                             valid_out_q;
  logic [MASK_BITS-1:0]             mask_out_q;
  logic [GLB_COUNTER_WIDTH-1:0]     start_time_out_q;

  logic                             start_acc;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic                             pop;
  logic                             head_late;
  logic                             issue_d;
  logic [CMD_W-1:0]                 head_dat;
  logic [MASK_BITS-1:0]             head_mask;
  logic [GLB_COUNTER_WIDTH-1:0]     head_start_time;

  // start is only honoured outside a load; it also flushes the command FIFO.
  assign start_acc = start & ((state_q == ST_IDLE) | (state_q == ST_RUN));

  assign cfg_ready = is_loading(state_q);
  assign busy      = is_loading(state_q);
  assign ready_run = (state_q == ST_RUN);
  assign cmd_ready = ~fifo_full;

  pulse_seq_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (start_acc),
    .push_i     (cmd_valid),
    .push_dat_i ({cmd_mask, cmd_start_time}),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign head_mask       = head_dat[CMD_W-1 -: MASK_BITS];
  assign head_start_time = head_dat[GLB_COUNTER_WIDTH-1:0];
  assign pop             = (state_q == ST_RUN) & ~fifo_empty & ~start;
  assign issue_d         = pop & ~head_late;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      q_q           <= '0;
      e_q           <= '0;
      def_wr_en_q   <= 1'b0;
      def_wr_sel_q  <= '0;
      def_wr_dat_q  <= '0;
      amp_wr_en_q   <= 1'b0;
      amp_wr_sel_q  <= '0;
      amp_wr_addr_q <= '0;
      amp_wr_dat_q  <= '0;
    end else begin
      def_wr_en_q <= 1'b0;
      amp_wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_RUN: begin
          if (start) begin
            state_q <= ST_LOAD_DEF;
            q_q     <= '0;
            e_q     <= '0;
          end
        end
        ST_LOAD_DEF: begin
          if (cfg_valid) begin
            def_wr_en_q  <= 1'b1;
            def_wr_sel_q <= q_q;
            def_wr_dat_q <= cfg_data[AMP_WIDTH-1:0];
            state_q      <= ST_LOAD_AMP;
          end
        end
        ST_LOAD_AMP: begin
          if (cfg_valid) begin
            amp_wr_en_q   <= 1'b1;
            amp_wr_sel_q  <= q_q;
            amp_wr_addr_q <= e_q;
            amp_wr_dat_q  <= cfg_data;
            if (e_q == LAST_E) begin
              e_q <= '0;
              if (q_q == LAST_Q) begin
                state_q <= ST_RUN;
              end else begin
                q_q     <= q_q + 1'b1;
                state_q <= ST_LOAD_DEF;
              end
            end else begin
              e_q <= e_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out_q      <= 1'b0;
      mask_out_q       <= '0;
      start_time_out_q <= '0;
    end else begin
      valid_out_q <= issue_d;
      if (issue_d) begin
        mask_out_q       <= head_mask;
        start_time_out_q <= head_start_time;
      end
    end
  end

`ifdef PULSE_SEQ_LATE_CHECK_EN
  logic [GLB_COUNTER_WIDTH-1:0] slack;
  logic                         late_err_q;

  // Modular slack: zero or "negative" (MSB set) means the slot has already passed.
  assign slack     = head_start_time - glb_counter;
  assign head_late = (slack == '0) | slack[GLB_COUNTER_WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      late_err_q <= 1'b0;
    end else if (start_acc) begin
      late_err_q <= 1'b0;
    end else if (pop && head_late) begin
      late_err_q <= 1'b1;
    end
  end

  assign late_err = late_err_q;
`else
  logic unused_glb;
  assign unused_glb = ^glb_counter;
  assign head_late  = 1'b0;
  assign late_err   = 1'b0;
`endif

  assign default_amp_wr_en   = def_wr_en_q;
  assign default_amp_wr_sel  = def_wr_sel_q;
  assign default_amp_wr_data = def_wr_dat_q;
  assign amp_memory_wr_en    = amp_wr_en_q;
  assign amp_memory_wr_sel   = amp_wr_sel_q;
  assign amp_memory_wr_addr  = amp_wr_addr_q;
  assign amp_memory_wr_data  = amp_wr_dat_q;
  assign valid_out           = valid_out_q;
  assign mask_out            = mask_out_q;
  assign start_time_out      = start_time_out_q;

endmodule

// File: tb/tb_pulse_init_sequencer.sv
// Randomized bench for pulse_init_sequencer against a queue-based model of the load stream and command path.
module tb_pulse_init_sequencer;

  localparam int NQ  = 2;
  localparam int QAW = 1;
  localparam int NE  = 4;
  localparam int EAW = 2;
  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int MW  = 2;
  localparam int GW  = 24;
  localparam int FD  = 4;
  localparam int MB  = NQ * MW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [GW-1:0] glb_counter = '0;
  logic          start = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [DW-1:0] cfg_data = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [MB-1:0] cmd_mask = '0;
  logic [GW-1:0] cmd_start_time = '0;
  logic          valid_out;
  logic [MB-1:0] mask_out;
  logic [GW-1:0] start_time_out;
  logic [QAW-1:0] amp_memory_wr_sel;
  logic          amp_memory_wr_en;
  logic [EAW-1:0] amp_memory_wr_addr;
  logic [DW-1:0] amp_memory_wr_data;
  logic [QAW-1:0] default_amp_wr_sel;
  logic          default_amp_wr_en;
  logic [AW-1:0] default_amp_wr_data;
  logic          busy;
  logic          ready_run;
  logic          late_err;

  pulse_init_sequencer #(
    .NUM_QUBIT(NQ), .QUBIT_ADDR_WIDTH(QAW), .AMP_MEMORY_NUM_ENTRY(NE),
    .AMP_MEMORY_ADDR_WIDTH(EAW), .AMP_MEMORY_DATA_WIDTH(DW), .AMP_WIDTH(AW),
    .MASK_WIDTH(MW), .GLB_COUNTER_WIDTH(GW), .CMD_FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .glb_counter(glb_counter), .start(start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mask(cmd_mask),
    .cmd_start_time(cmd_start_time), .valid_out(valid_out), .mask_out(mask_out),
    .start_time_out(start_time_out), .amp_memory_wr_sel(amp_memory_wr_sel),
    .amp_memory_wr_en(amp_memory_wr_en), .amp_memory_wr_addr(amp_memory_wr_addr),
    .amp_memory_wr_data(amp_memory_wr_data), .default_amp_wr_sel(default_amp_wr_sel),
    .default_amp_wr_en(default_amp_wr_en), .default_amp_wr_data(default_amp_wr_data),
    .busy(busy), .ready_run(ready_run), .late_err(late_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_amp;
    int unsigned sel;
    int unsigned addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [MB-1:0] mask;
    logic [GW-1:0] st;
  } cmd_t;

  wr_t  exp_wr[$];
  cmd_t exp_cmd[$];
  int   vcyc[$];
  bit   exp_late = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  wr_t  mon_w;
  cmd_t mon_c;
  wr_t  last_def;
  wr_t  last_amp;
  bit   def_seen = 1'b0;
  bit   amp_seen = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // A command is late when its start time is not strictly in the future, modulo 2^GW.
  function automatic bit late_rule(input logic [GW-1:0] st, input logic [GW-1:0] g);
`ifdef PULSE_SEQ_LATE_CHECK_EN
    longint m;
    longint d;
    m = longint'(1) << GW;
    d = (longint'(st) - longint'(g) + m) % m;
    return (d == 0) || (d >= (m / 2));
`else
    return 1'b0;
`endif
  endfunction

  // Beat k of a load: every (NE+1)-th beat is a qubit's default amp, the rest fill its memory.
  task automatic plan_load(input logic [DW-1:0] base);
    wr_t w;
    exp_wr.delete();
    for (int k = 0; k < NQ * (NE + 1); k++) begin
      w.is_amp = (k % (NE + 1)) != 0;
      w.sel    = k / (NE + 1);
      w.addr   = w.is_amp ? (k % (NE + 1)) - 1 : 0;
      w.data   = base + DW'(k);
      exp_wr.push_back(w);
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_cmd.delete();
    exp_late = 1'b0;
  endtask

  task automatic send_cfg(input logic [DW-1:0] base, input int n, input bit gaps);
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      cfg_valid = 1'b1;
      cfg_data  = base + DW'(i);
      t = 0;
      while (!cfg_ready && t < 300) begin @(posedge clk); #1; t++; end
      if (!cfg_ready) chk("cfg_rdy_timeout", 64'(cfg_ready), 64'(1));
      @(posedge clk); #1;
      cfg_valid = 1'b0;
    end
  endtask

  task automatic push_cmd(input logic [MB-1:0] m, input logic [GW-1:0] st);
    int   t;
    cmd_t c;
    cmd_valid      = 1'b1;
    cmd_mask       = m;
    cmd_start_time = st;
    t = 0;
    while (!cmd_ready && t < 300) begin @(posedge clk); #1; t++; end
    if (!cmd_ready) begin
      chk("cmd_push_timeout", 64'(cmd_ready), 64'(1));
    end else begin
      @(posedge clk); #1;
      c.mask = m;
      c.st   = st;
      if (late_rule(st, glb_counter)) exp_late = 1'b1;
      else exp_cmd.push_back(c);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_cmd.size() != 0 && t < 300) begin @(posedge clk); #1; t++; end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_left", 64'(exp_cmd.size()), 64'(0));
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (default_amp_wr_en) begin
        if (exp_wr.size() == 0) begin
          chk("def_wr_spurious", 64'(default_amp_wr_en), 64'(0));
        end else begin
          mon_w = exp_wr.pop_front();
          chk("def_wr_kind", 64'(mon_w.is_amp), 64'(0));
          chk("def_wr_sel", 64'(default_amp_wr_sel), 64'(mon_w.sel));
          chk("def_wr_data", 64'(default_amp_wr_data), 64'(mon_w.data[AW-1:0]));
          last_def = mon_w;
          def_seen = 1'b1;
        end
      end else if (def_seen) begin
        chk("def_hold_sel", 64'(default_amp_wr_sel), 64'(last_def.sel));
        chk("def_hold_data", 64'(default_amp_wr_data), 64'(last_def.data[AW-1:0]));
      end
      if (amp_memory_wr_en) begin
        if (exp_wr.size() == 0) begin
          chk("amp_wr_spurious", 64'(amp_memory_wr_en), 64'(0));
        end else begin
          mon_w = exp_wr.pop_front();
          chk("amp_wr_kind", 64'(mon_w.is_amp), 64'(1));
          chk("amp_wr_sel", 64'(amp_memory_wr_sel), 64'(mon_w.sel));
          chk("amp_wr_addr", 64'(amp_memory_wr_addr), 64'(mon_w.addr));
          chk("amp_wr_data", 64'(amp_memory_wr_data), 64'(mon_w.data));
          last_amp = mon_w;
          amp_seen = 1'b1;
        end
      end else if (amp_seen) begin
        chk("amp_hold_addr", 64'(amp_memory_wr_addr), 64'(last_amp.addr));
        chk("amp_hold_data", 64'(amp_memory_wr_data), 64'(last_amp.data));
      end
      if (valid_out) begin
        chk("vld_in_run", 64'(ready_run), 64'(1));
        vcyc.push_back(cyc);
        if (exp_cmd.size() == 0) begin
          chk("vld_spurious", 64'(valid_out), 64'(0));
        end else begin
          mon_c = exp_cmd.pop_front();
          chk("mask_out", 64'(mask_out), 64'(mon_c.mask));
          chk("start_time_out", 64'(start_time_out), 64'(mon_c.st));
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cfg_ready"}, 64'(cfg_ready), 64'(0));
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_ready_run"}, 64'(ready_run), 64'(0));
    chk({tag, "_valid_out"}, 64'(valid_out), 64'(0));
    chk({tag, "_late_err"}, 64'(late_err), 64'(0));
    chk({tag, "_def_en"}, 64'(default_amp_wr_en), 64'(0));
    chk({tag, "_def_data"}, 64'(default_amp_wr_data), 64'(0));
    chk({tag, "_amp_en"}, 64'(amp_memory_wr_en), 64'(0));
    chk({tag, "_amp_addr"}, 64'(amp_memory_wr_addr), 64'(0));
    chk({tag, "_amp_data"}, 64'(amp_memory_wr_data), 64'(0));
    chk({tag, "_mask_out"}, 64'(mask_out), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] base;
    int            ncmd;

    #1;
    chk_all_zero("rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed load of 0x100.. with three commands queued before any beat.
    plan_load(32'h100);
    do_start();
    chk("busy_load", 64'(busy), 64'(1));
    chk("cfg_rdy_load", 64'(cfg_ready), 64'(1));
    chk("run_load", 64'(ready_run), 64'(0));
    vcyc.delete();
    for (int i = 0; i < 3; i++) push_cmd(MB'($urandom), GW'($urandom_range(1000, 5000)));
    send_cfg(32'h100, NQ * (NE + 1), 1'b0);
    @(negedge clk); #1;
    chk("load1_writes_left", 64'(exp_wr.size()), 64'(0));
    chk("load1_ready_run", 64'(ready_run), 64'(1));
    chk("load1_busy", 64'(busy), 64'(0));
    wait_drain();
    chk("burst_count", 64'(vcyc.size()), 64'(3));
    if (vcyc.size() >= 3) begin
      chk("burst_gap1", 64'(vcyc[1] - vcyc[0]), 64'(1));
      chk("burst_gap2", 64'(vcyc[2] - vcyc[1]), 64'(1));
    end

    // FIFO fills during a stalled load; the fifth command waits for RUN.
    plan_load(32'h200);
    do_start();
    vcyc.delete();
    for (int i = 0; i < FD; i++) push_cmd(MB'($urandom), GW'($urandom_range(1000, 5000)));
    chk("cmd_rdy_full", 64'(cmd_ready), 64'(0));
    fork
      push_cmd(MB'($urandom), GW'($urandom_range(1000, 5000)));
      begin
        repeat (4) begin
          @(posedge clk); #2;
          chk("cmd_rdy_held", 64'(cmd_ready), 64'(0));
          chk("no_vld_load", 64'(valid_out), 64'(0));
        end
        send_cfg(32'h200, NQ * (NE + 1), 1'b1);
      end
    join
    wait_drain();
    chk("full_case_count", 64'(vcyc.size()), 64'(FD + 1));

    // Wrapped-time issue and a start time equal to now.
    glb_counter = 24'hFFFFF0;
    vcyc.delete();
    push_cmd(MB'($urandom), 24'h000005);
    push_cmd(MB'($urandom), 24'hFFFFF0);
    wait_drain();
    chk("wrap_issue_count", 64'(vcyc.size()), 64'(1 + (late_rule(24'hFFFFF0, 24'hFFFFF0) ? 0 : 1)));
    chk("late_err_after_wrap", 64'(late_err), 64'(exp_late));

    // Randomized rounds: cfg gaps, commands racing the load, start times near now.
    for (int r = 0; r < 4; r++) begin
      base = $urandom;
      plan_load(base);
      do_start();
      chk("late_err_cleared", 64'(late_err), 64'(0));
      glb_counter = GW'($urandom);
      ncmd = $urandom_range(2, 7);
      fork
        send_cfg(base, NQ * (NE + 1), 1'b1);
        for (int i = 0; i < ncmd; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          push_cmd(MB'($urandom), glb_counter + GW'($urandom_range(0, 8)) - GW'(4));
        end
      join
      wait_drain();
      chk("rnd_writes_left", 64'(exp_wr.size()), 64'(0));
      chk("rnd_late_err", 64'(late_err), 64'(exp_late));
    end

    // Reset in the middle of a load, then a fresh load from qubit 0, entry 0.
    plan_load(32'h300);
    do_start();
    send_cfg(32'h300, 3, 1'b0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    exp_wr.delete();
    exp_cmd.delete();
    exp_late = 1'b0;
    def_seen = 1'b0;
    amp_seen = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    plan_load(32'h400);
    do_start();
    send_cfg(32'h400, NQ * (NE + 1), 1'b1);
    @(negedge clk); #1;
    chk("reload_writes_left", 64'(exp_wr.size()), 64'(0));
    chk("reload_ready_run", 64'(ready_run), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
